// File: rtl/game_pkg.sv
// Shared types and constants for the player movement block.
package game_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, STEP, RECENTER} state_t;

    localparam int NUM_BTN = 5;
    localparam int UP      = 0;
    localparam int LEFT    = 1;
    localparam int RIGHT   = 2;
    localparam int CENTRE  = 3;
    localparam int DOWN    = 4;

    localparam int DEF_SCR_W = 640;
    localparam int DEF_SCR_H = 480;
    localparam int DEF_SPR   = 16;

    // Result of moving one axis: new coordinate and a saturation flag.
    typedef struct packed {
        logic [9:0] pos;
        logic       sat;
    } axis_t;

    // One-axis step with saturation at 0 and lim; opposing requests cancel.
    function automatic axis_t axis_step(input logic [10:0] pos,
                                        input logic [10:0] step,
                                        input logic [10:0] lim,
                                        input logic        dec,
                                        input logic        inc);
        axis_t       r;
        logic [10:0] sum;
        r.pos = pos[9:0];
        r.sat = 1'b0;
        sum   = pos + step;
        if (dec && !inc) begin
            if (pos < step) begin
                r.pos = '0;
                r.sat = 1'b1;
            end else begin
                r.pos = 10'(pos - step);
            end
        end else if (inc && !dec) begin
            if (sum > lim) begin
                r.pos = lim[9:0];
                r.sat = 1'b1;
            end else begin
                r.pos = sum[9:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one button.
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Level flips after DB_CYCLES consecutive differing samples; any agreement clears the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] != dout) begin
                if (cnt == CW'(DB_CYCLES - 1)) begin
                    dout <= sync[1];
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/player_move_ctrl.sv
// Sprite movement controller: debounced buttons drive a per-frame stepping FSM
// with saturating position arithmetic and a centre (recenter) command.
module player_move_ctrl
    import game_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000,
    parameter int SCR_W     = DEF_SCR_W,
    parameter int SCR_H     = DEF_SCR_H,
    parameter int SPR       = DEF_SPR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn,
    input  logic [1:0] sw,
    input  logic       frame_tick,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       moving,
    output logic       hit_edge
);
    localparam logic [10:0] X_MAX = 11'(SCR_W - SPR);
    localparam logic [10:0] Y_MAX = 11'(SCR_H - SPR);
    localparam logic [9:0]  X_CTR = 10'((SCR_W - SPR) / 2);
    localparam logic [9:0]  Y_CTR = 10'((SCR_H - SPR) / 2);

    logic [NUM_BTN-1:0] db;
    state_t             state, state_nxt;
    logic               ctr_lock;
    logic               dir_any, ctr_req;
    logic [10:0]        step;
    axis_t              ax, ay;

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_db
            btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
                .clk  (clk),
                .rst  (rst),
                .din  (btn[g]),
                .dout (db[g])
            );
        end
    endgenerate

    assign dir_any = db[UP] | db[LEFT] | db[RIGHT] | db[DOWN];
    // Centre only fires again after it has been released since the last recenter.
    assign ctr_req = db[CENTRE] & ~ctr_lock;

    // Candidate step for both axes; only committed in the STEP cycle, which samples sw.
    always_comb begin
        step = 11'(sw) + 11'd1;
        ax   = axis_step({1'b0, pos_x}, step, X_MAX, db[LEFT], db[RIGHT]);
        ay   = axis_step({1'b0, pos_y}, step, Y_MAX, db[UP],   db[DOWN]);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; centre takes priority over directions.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ctr_req)      state_nxt = RECENTER;
                else if (dir_any) state_nxt = ARMED;
            end
            ARMED: begin
                if (ctr_req)         state_nxt = RECENTER;
                else if (!dir_any)   state_nxt = IDLE;
                else if (frame_tick) state_nxt = STEP;
            end
            STEP:     state_nxt = dir_any ? ARMED : IDLE;
            RECENTER: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Position, status pulses and centre re-arm lock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_x    <= X_CTR;
            pos_y    <= Y_CTR;
            moving   <= 1'b0;
            hit_edge <= 1'b0;
            ctr_lock <= 1'b0;
        end else begin
            moving   <= 1'b0;
            hit_edge <= 1'b0;
            if (state == STEP) begin
                pos_x    <= ax.pos;
                pos_y    <= ay.pos;
                moving   <= (ax.pos != pos_x) || (ay.pos != pos_y);
                hit_edge <= ax.sat | ay.sat;
            end else if (state == RECENTER) begin
                pos_x  <= X_CTR;
                pos_y  <= Y_CTR;
                moving <= (pos_x != X_CTR) || (pos_y != Y_CTR);
            end
            if (state == RECENTER)  ctr_lock <= 1'b1;
            else if (!db[CENTRE])   ctr_lock <= 1'b0;
        end
    end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl with a short debounce window.
module tb_player_move_ctrl;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;
    logic [1:0] sw;
    logic       frame_tick;
    logic [9:0] pos_x, pos_y;
    logic       moving, hit_edge;

    int checks   = 0;
    int failures = 0;
    int mov_tot  = 0;
    int hit_tot  = 0;

    player_move_ctrl #(.DB_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .sw         (sw),
        .frame_tick (frame_tick),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .moving     (moving),
        .hit_edge   (hit_edge)
    );

    always #5 clk = ~clk;

    // Count output pulses on the inactive edge.
    always @(negedge clk) begin
        if (moving)   mov_tot++;
        if (hit_edge) hit_tot++;
    end

    typedef struct {
        logic [4:0] b;
        logic [1:0] s;
        int         ex, ey, em, eh;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle frame_tick; returns 1 ns after the edge that samples it.
    task automatic tick();
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    int m0, h0, px, py;

    initial begin
        //        btn       sw    x    y   mov hit
        vecs[0] = '{5'b00100, 2'd3, 316, 232, 1, 0};  // right, step 4
        vecs[1] = '{5'b00110, 2'd3, 316, 232, 0, 0};  // left+right cancel
        vecs[2] = '{5'b00101, 2'd0, 317, 231, 1, 0};  // up+right diagonal
        vecs[3] = '{5'b10001, 2'd2, 317, 231, 0, 0};  // up+down cancel
        vecs[4] = '{5'b10000, 2'd1, 317, 233, 1, 0};  // down, step 2
        vecs[5] = '{5'b10010, 2'd3, 313, 237, 1, 0};  // left+down

        rst = 1'b0; btn = '0; sw = '0; frame_tick = 1'b0;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(10);
        chk("reset_x", int'(pos_x), 312);
        chk("reset_y", int'(pos_y), 232);
        chk("reset_state", int'(dut.state), int'(IDLE));
        chk("reset_moving", mov_tot, 0);
        chk("reset_hit", hit_tot, 0);

        // 3-cycle glitch must not reach the FSM; tick in IDLE is ignored.
        btn = 5'b00100; wait_cyc(3); btn = '0;
        wait_cyc(10);
        chk("glitch_state", int'(dut.state), int'(IDLE));
        tick(); wait_cyc(4);
        chk("glitch_x", int'(pos_x), 312);
        chk("glitch_moving", mov_tot, 0);

        px = 312; py = 232;
        for (int i = 0; i < 6; i++) begin
            btn = vecs[i].b; sw = vecs[i].s;
            wait_cyc(12);
            m0 = mov_tot; h0 = hit_tot;
            tick();
            chk($sformatf("v%0d_lat_x", i), int'(pos_x), px);
            chk($sformatf("v%0d_lat_y", i), int'(pos_y), py);
            wait_cyc(1);
            chk($sformatf("v%0d_x", i), int'(pos_x), vecs[i].ex);
            chk($sformatf("v%0d_y", i), int'(pos_y), vecs[i].ey);
            wait_cyc(3);
            chk($sformatf("v%0d_moving", i), mov_tot - m0, vecs[i].em);
            chk($sformatf("v%0d_hit", i), hit_tot - h0, vecs[i].eh);
            btn = '0;
            wait_cyc(12);
            px = vecs[i].ex; py = vecs[i].ey;
        end

        // Left saturation from x=313 with step 4: tick 79 clamps, tick 80 is already at the edge.
        btn = 5'b00010; sw = 2'd3;
        wait_cyc(12);
        m0 = mov_tot; h0 = hit_tot;
        for (int i = 0; i < 79; i++) begin
            tick(); wait_cyc(2);
        end
        chk("sat_x", int'(pos_x), 0);
        chk("sat_moves", mov_tot - m0, 79);
        chk("sat_clamp_hit", hit_tot - h0, 1);
        m0 = mov_tot; h0 = hit_tot;
        tick(); wait_cyc(2);
        chk("edge_moving", mov_tot - m0, 0);
        chk("edge_hit", hit_tot - h0, 1);
        btn = '0; wait_cyc(12);

        // Up saturation to y=0.
        btn = 5'b00001;
        wait_cyc(12);
        for (int i = 0; i < 62; i++) begin
            tick(); wait_cyc(2);
        end
        chk("origin_x", int'(pos_x), 0);
        chk("origin_y", int'(pos_y), 0);
        btn = '0; wait_cyc(12);

        // Centre and down together: recenter wins, no down step.
        m0 = mov_tot; h0 = hit_tot;
        btn = 5'b11000;
        wait_cyc(20);
        chk("ctr_x", int'(pos_x), 312);
        chk("ctr_y", int'(pos_y), 232);
        chk("ctr_moving", mov_tot - m0, 1);
        chk("ctr_hit", hit_tot - h0, 0);
        btn = '0; wait_cyc(12);

        // Move off centre, then reset during the STEP cycle.
        btn = 5'b00100; sw = 2'd0;
        wait_cyc(12);
        tick(); wait_cyc(3);
        chk("pre_rst_x", int'(pos_x), 313);
        tick();
        chk("in_step", int'(dut.state), int'(STEP));
        m0 = mov_tot;
        rst = 1'b0;
        wait_cyc(2);
        rst = 1'b1;
        btn = '0;
        wait_cyc(6);
        chk("rst_step_x", int'(pos_x), 312);
        chk("rst_step_y", int'(pos_y), 232);
        chk("rst_step_moving", mov_tot - m0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
